// File: rtl/fft_spectrum_reader.sv
// Post-FFT spectrum sweeper: reads a bin range over the DMA bus, streams re^2+im^2 with index/last/exponent.
// Optional running-peak outputs are compiled in when FFT_SPECTRUM_PEAK_EN is defined.
module fft_spectrum_reader #(
   parameter  int FFT_LENGTH = 1024,
   parameter  int FFT_DW     = 16,
   parameter  int BIN_START  = 0,
   parameter  int NUM_BINS   = 512,
   parameter  int RAM_LAT    = 1,
   parameter  int FIFO_DEPTH = 4,
   localparam int FFT_N      = $clog2(FFT_LENGTH),
   localparam int MAG_W      = 2*FFT_DW+1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     done_fft,
   input  logic [7:0]               bfpexp_i,
   output logic                     dmaact,
   output logic [FFT_N-1:0]         dmaa,
   input  logic signed [FFT_DW-1:0] dmadr_real,
   input  logic signed [FFT_DW-1:0] dmadr_imag,
   output logic                     mag_valid,
   input  logic                     mag_ready,
   output logic [MAG_W-1:0]         mag_data,
   output logic [FFT_N-1:0]         mag_index,
   output logic                     mag_last,
   output logic [7:0]               mag_bfpexp,
   output logic                     busy,
   output logic                     frame_done
`ifdef FFT_SPECTRUM_PEAK_EN
   ,
   output logic [MAG_W-1:0]         peak_mag,
   output logic [FFT_N-1:0]         peak_index,
   output logic                     peak_valid
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH+1);
   localparam int SQ_W  = 2*FFT_DW;
   localparam int EW    = MAG_W + FFT_N + 1;
   localparam logic [FFT_N-1:0] START_ADDR = FFT_N'(BIN_START);
   localparam logic [FFT_N-1:0] LAST_ADDR  = FFT_N'(BIN_START + NUM_BINS - 1);

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

   state_t           r_state, w_state_next;
   logic [FFT_N-1:0] r_addr;
   logic             r_armed;
   logic [7:0]       r_bfpexp;
   logic [CNT_W-1:0] r_inflight;
   logic [CNT_W-1:0] r_mem_cnt;
   logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
   logic             r_out_valid;
   logic [EW-1:0]    r_out;
   logic [EW-1:0]    r_mem [FIFO_DEPTH];

   logic             r_lat_vld [RAM_LAT];
   logic [FFT_N-1:0] r_lat_idx [RAM_LAT];
   logic             r_sq_vld, r_sum_vld;
   logic [SQ_W-1:0]  r_sq_re, r_sq_im;
   logic [FFT_N-1:0] r_sq_idx, r_sum_idx;
   logic [MAG_W-1:0] r_sum;

   logic             w_pop, w_wr, w_issue, w_start, w_full;
   logic             w_load, w_from_mem, w_bypass, w_mem_wr;
   logic [CNT_W-1:0] w_total;
   logic [CNT_W:0]   w_credit;
   logic [EW-1:0]    w_wdata;
   logic signed [SQ_W-1:0] w_re_ext, w_im_ext;

   assign w_pop   = r_out_valid && mag_ready;
   assign w_wr    = r_sum_vld;
   assign w_total = r_mem_cnt + CNT_W'(r_out_valid);
   assign w_full  = (w_total == CNT_W'(FIFO_DEPTH));
   // A beat leaving this cycle frees its slot now; occupancy+in-flight never exceeds the depth.
   assign w_credit = (CNT_W+1)'(FIFO_DEPTH) - {1'b0, w_total} + {{CNT_W{1'b0}}, w_pop};
   assign w_issue  = (r_state == S_SWEEP) && (w_credit > {1'b0, r_inflight});
   assign w_start  = (r_state == S_IDLE) && done_fft && r_armed;

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_next = S_SWEEP;
         S_SWEEP: if (w_issue && r_addr == LAST_ADDR) w_state_next = S_DRAIN;
         S_DRAIN: if (r_inflight == '0 && w_total == CNT_W'(w_pop)) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_addr     <= '0;
         r_armed    <= 1'b1;
         r_bfpexp   <= '0;
         r_inflight <= '0;
      end else begin
         if (w_start) begin
            r_addr   <= START_ADDR;
            r_bfpexp <= bfpexp_i;
            r_armed  <= 1'b0;
         end else if (r_state == S_IDLE && !done_fft) begin
            r_armed  <= 1'b1;
         end
         if (w_issue) r_addr <= r_addr + 1'b1;
         r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_wr);
      end
   end

   generate
      for (genvar gi = 0; gi < RAM_LAT; gi++) begin : g_lat
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (!reset) r_lat_vld[gi] <= 1'b0;
               else        r_lat_vld[gi] <= w_issue;
               r_lat_idx[gi] <= r_addr;
            end
         end else begin : g_rest
            always_ff @(posedge clk) begin
               if (!reset) r_lat_vld[gi] <= 1'b0;
               else        r_lat_vld[gi] <= r_lat_vld[gi-1];
               r_lat_idx[gi] <= r_lat_idx[gi-1];
            end
         end
      end
   endgenerate

   assign w_re_ext = {{FFT_DW{dmadr_real[FFT_DW-1]}}, dmadr_real};
   assign w_im_ext = {{FFT_DW{dmadr_imag[FFT_DW-1]}}, dmadr_imag};

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sq_vld  <= 1'b0;
         r_sum_vld <= 1'b0;
      end else begin
         r_sq_vld  <= r_lat_vld[RAM_LAT-1];
         r_sum_vld <= r_sq_vld;
      end
      r_sq_re   <= w_re_ext * w_re_ext;
      r_sq_im   <= w_im_ext * w_im_ext;
      r_sq_idx  <= r_lat_idx[RAM_LAT-1];
      // Squares are non-negative, so zero extension keeps the full exact sum.
      r_sum     <= MAG_W'(r_sq_re) + MAG_W'(r_sq_im);
      r_sum_idx <= r_sq_idx;
   end

   assign w_wdata    = {(r_sum_idx == LAST_ADDR), r_sum_idx, r_sum};
   assign w_load     = !r_out_valid || w_pop;
   assign w_from_mem = w_load && (r_mem_cnt != '0);
   assign w_bypass   = w_load && (r_mem_cnt == '0) && w_wr;
   assign w_mem_wr   = w_wr && !w_bypass;

   always_ff @(posedge clk) begin
      if (w_mem_wr) r_mem[r_wr_ptr] <= w_wdata;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_mem_cnt   <= '0;
         r_out_valid <= 1'b0;
         r_out       <= '0;
      end else begin
         if (w_load) begin
            if (w_from_mem) begin
               r_out       <= r_mem[r_rd_ptr];
               r_out_valid <= 1'b1;
               r_rd_ptr    <= r_rd_ptr + 1'b1;
            end else if (w_bypass) begin
               r_out       <= w_wdata;
               r_out_valid <= 1'b1;
            end else begin
               r_out_valid <= 1'b0;
            end
         end
         if (w_mem_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         r_mem_cnt <= r_mem_cnt + CNT_W'(w_mem_wr) - CNT_W'(w_from_mem);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(w_wr && w_full && !w_pop));

   assign dmaact     = w_issue;
   assign dmaa       = r_addr;
   assign mag_valid  = r_out_valid;
   assign mag_data   = r_out[MAG_W-1:0];
   assign mag_index  = r_out[MAG_W +: FFT_N];
   assign mag_last   = r_out[EW-1];
   assign mag_bfpexp = r_bfpexp;
   assign busy       = (r_state == S_SWEEP) || (r_state == S_DRAIN);
   assign frame_done = (r_state == S_DONE);

`ifdef FFT_SPECTRUM_PEAK_EN
   logic r_peak_any;

   // Bins arrive in ascending order, so a strict compare keeps the lower index on ties.
   always_ff @(posedge clk) begin
      if (!reset) begin
         peak_mag   <= '0;
         peak_index <= '0;
         r_peak_any <= 1'b0;
      end else if (w_start) begin
         peak_mag   <= '0;
         peak_index <= '0;
         r_peak_any <= 1'b0;
      end else if (w_wr && (!r_peak_any || r_sum > peak_mag)) begin
         peak_mag   <= r_sum;
         peak_index <= r_sum_idx;
         r_peak_any <= 1'b1;
      end
   end

   assign peak_valid = (r_state == S_DONE);
`endif

endmodule

// File: tb/tb_fft_spectrum_reader.sv
// Directed bench for fft_spectrum_reader: default instance for full sweeps, small-range instance for offset/peak.
module tb_fft_spectrum_reader;

   localparam int NB = 512;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset, done_fft, dmaact, mag_valid, mag_ready, mag_last, busy, frame_done;
   logic [7:0]         bfpexp_i, mag_bfpexp;
   logic [9:0]         dmaa, mag_index;
   logic signed [15:0] ram_re, ram_im;
   logic [32:0]        mag_data;

   logic               done_b, dmaact_b, valid_b, ready_b, last_b, busy_b, fd_b;
   logic [7:0]         bfp_b, bfpo_b;
   logic [9:0]         dmaa_b, idx_b;
   logic signed [15:0] re_b, im_b;
   logic [32:0]        data_b;
`ifdef FFT_SPECTRUM_PEAK_EN
   logic [32:0] pkm_a, pkm_b;
   logic [9:0]  pki_a, pki_b;
   logic        pkv_a, pkv_b;
`endif

   fft_spectrum_reader u_dut (
      .clk(clk), .reset(reset), .done_fft(done_fft), .bfpexp_i(bfpexp_i),
      .dmaact(dmaact), .dmaa(dmaa), .dmadr_real(ram_re), .dmadr_imag(ram_im),
      .mag_valid(mag_valid), .mag_ready(mag_ready), .mag_data(mag_data),
      .mag_index(mag_index), .mag_last(mag_last), .mag_bfpexp(mag_bfpexp),
      .busy(busy), .frame_done(frame_done)
`ifdef FFT_SPECTRUM_PEAK_EN
      , .peak_mag(pkm_a), .peak_index(pki_a), .peak_valid(pkv_a)
`endif
   );

   fft_spectrum_reader #(.BIN_START(100), .NUM_BINS(8)) u_dut_b (
      .clk(clk), .reset(reset), .done_fft(done_b), .bfpexp_i(bfp_b),
      .dmaact(dmaact_b), .dmaa(dmaa_b), .dmadr_real(re_b), .dmadr_imag(im_b),
      .mag_valid(valid_b), .mag_ready(ready_b), .mag_data(data_b),
      .mag_index(idx_b), .mag_last(last_b), .mag_bfpexp(bfpo_b),
      .busy(busy_b), .frame_done(fd_b)
`ifdef FFT_SPECTRUM_PEAK_EN
      , .peak_mag(pkm_b), .peak_index(pki_b), .peak_valid(pkv_b)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // RAM models: re=bin, im=-bin, except bin 7 which carries the most negative value on both.
   function automatic logic signed [15:0] f_re(input logic [9:0] a);
      if (a == 10'd7) return 16'sh8000;
      return $signed({6'd0, a});
   endfunction
   function automatic logic signed [15:0] f_im(input logic [9:0] a);
      if (a == 10'd7) return 16'sh8000;
      return -$signed({6'd0, a});
   endfunction
   function automatic logic [63:0] exp_mag(input int bin);
      if (bin == 7) return 64'h0_8000_0000;
      return 64'(2 * bin * bin);
   endfunction

   // Small-range instance: bins 103 and 106 tie for the maximum (3400).
   function automatic logic signed [15:0] fb_re(input logic [9:0] a);
      if (a == 10'd103 || a == 10'd106) return 16'sd50;
      return $signed(16'({6'd0, a}) - 16'd100);
   endfunction
   function automatic logic signed [15:0] fb_im(input logic [9:0] a);
      if (a == 10'd103) return -16'sd30;
      if (a == 10'd106) return 16'sd30;
      return 16'sd1;
   endfunction

   logic [63:0] exp_b [8] = '{64'd1, 64'd2, 64'd5, 64'd3400, 64'd17, 64'd26, 64'd3400, 64'd50};

   always @(posedge clk) begin
      if (dmaact) begin
         ram_re <= f_re(dmaa);
         ram_im <= f_im(dmaa);
      end
      if (dmaact_b) begin
         re_b <= fb_re(dmaa_b);
         im_b <= fb_im(dmaa_b);
      end
   end

   bit tog_en = 1'b0;
   initial begin
      int k = 0;
      mag_ready = 1'b1;
      ready_b   = 1'b1;
      forever begin
         @(posedge clk); #1;
         k++;
         mag_ready = tog_en ? (k % 3 == 0) : 1'b1;
      end
   end

   // Monitor for the default instance, sampled on the falling edge.
   bit mon_en  = 1'b0;
   int clr_gen = 0;
   int exp_idx, n_iss, n_acc, n_thr, n_sweeps, first_cyc, last_cyc;
   initial begin
      int  tb_cyc = 0;
      int  seen_gen = 0;
      bit  prev_busy = 1'b0;
      bit  stalled = 1'b0;
      n_sweeps = 0; exp_idx = 0; n_iss = 0; n_acc = 0; n_thr = 0; first_cyc = 0; last_cyc = 0;
      forever begin
         @(negedge clk);
         tb_cyc++;
         if (clr_gen != seen_gen) begin
            seen_gen = clr_gen;
            exp_idx = 0; n_iss = 0; n_acc = 0; n_thr = 0; stalled = 1'b0;
         end
         if (busy && !prev_busy) n_sweeps++;
         prev_busy = busy;
         if (mon_en) begin
            if (stalled) check("stall_valid", mag_valid, 1);
            if (mag_valid) begin
               check("beat_index", mag_index, exp_idx);
               check("beat_data", mag_data, exp_mag(exp_idx));
               check("beat_last", mag_last, exp_idx == NB-1);
            end
            if (mag_valid && mag_ready) begin
               if (exp_idx == 0) first_cyc = tb_cyc;
               if (mag_last) last_cyc = tb_cyc;
               exp_idx++;
               n_acc++;
            end
            if (dmaact) begin
               check("dmaa", dmaa, n_iss);
               n_iss++;
               check("fifo_occupancy", (n_iss - n_acc) <= 4, 1);
            end
            if (busy && !dmaact && n_iss < NB) n_thr++;
            if (frame_done) check("frame_done_latency", tb_cyc - last_cyc, 1);
            stalled = mag_valid && !mag_ready;
         end
      end
   end

   task automatic wait_fd(input string tag, input int lim);
      bit seen = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (frame_done) begin
            seen = 1'b1;
            break;
         end
      end
      check(tag, seen, 1);
   endtask

   task automatic rearm();
      @(posedge clk); #1;
      done_fft = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      bit ok;
      int lat, nb;
      reset = 1'b0; done_fft = 1'b0; bfpexp_i = 8'h00; done_b = 1'b0; bfp_b = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mag_valid", mag_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_dmaact", dmaact, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_mag_data", mag_data, 0);
      check("rst_bfpexp", mag_bfpexp, 0);
      @(posedge clk); #1;
      reset = 1'b1; mon_en = 1'b1; clr_gen++;
      repeat (2) @(posedge clk);
      #1;

      // Frame A: full-rate sweep including the extreme-value bin.
      bfpexp_i = 8'hF3; done_fft = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy) begin ok = 1'b1; break; end
      end
      check("sweep_start", ok, 1);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lat++;
         if (mag_valid) break;
      end
      check("first_valid_latency", lat, 4);
      check("bfpexp_a", mag_bfpexp, 8'hF3);
      wait_fd("frame_a_done", 5000);
      check("frame_a_beats", n_acc, NB);
      check("frame_a_throughput", last_cyc - first_cyc, NB-1);
      $display("[TB] frame A: beats=%0d span=%0d bfpexp=%0h", n_acc, last_cyc - first_cyc, mag_bfpexp);

      // Held done_fft must not retrigger.
      repeat (3000) @(negedge clk);
      check("single_sweep", n_sweeps, 1);
      check("idle_busy", busy, 0);
      $display("[TB] hold: sweeps=%0d after 3000 cycles", n_sweeps);

      // Frame B: re-armed, new exponent, consumer accepts 1 of 3 cycles.
      rearm();
      bfpexp_i = 8'h05; clr_gen++; tog_en = 1'b1; done_fft = 1'b1;
      wait_fd("frame_b_done", 5000);
      tog_en = 1'b0;
      check("frame_b_beats", n_acc, NB);
      check("frame_b_sweeps", n_sweeps, 2);
      check("bfpexp_b", mag_bfpexp, 8'h05);
      check("throttled", n_thr > 0, 1);
      $display("[TB] frame B: beats=%0d throttled_cycles=%0d bfpexp=%0h", n_acc, n_thr, mag_bfpexp);

      // Frame C: reset mid-sweep at bin 200, then restart with done_fft still high.
      rearm();
      clr_gen++; done_fft = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (mag_valid && mag_index == 10'd200) begin ok = 1'b1; break; end
      end
      check("reach_bin_200", ok, 1);
      mon_en = 1'b0; reset = 1'b0;
      @(negedge clk);
      check("midrst_valid", mag_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_dmaact", dmaact, 0);
      @(posedge clk); #1;
      clr_gen++; mon_en = 1'b1; reset = 1'b1;
      wait_fd("frame_d_done", 5000);
      check("frame_d_beats", n_acc, NB);
      check("frame_d_sweeps", n_sweeps, 4);
      $display("[TB] frame D after reset: beats=%0d sweeps=%0d", n_acc, n_sweeps);

      // Offset range on the second instance.
      @(posedge clk); #1;
      bfp_b = 8'h7E; done_b = 1'b1;
      nb = 0;
      for (int i = 0; i < 60 && nb < 8; i++) begin
         @(negedge clk);
         if (valid_b) begin
            check("b_index", idx_b, 100 + nb);
            check("b_data", data_b, exp_b[nb]);
            check("b_last", last_b, nb == 7);
            nb++;
         end
      end
      check("b_beats", nb, 8);
      @(negedge clk);
      check("b_frame_done", fd_b, 1);
      check("b_bfpexp", bfpo_b, 8'h7E);
`ifdef FFT_SPECTRUM_PEAK_EN
      check("b_peak_valid", pkv_b, 1);
      check("b_peak_index", pki_b, 103);
      check("b_peak_mag", pkm_b, 3400);
`endif
      $display("[TB] frame offset: beats=%0d frame_done=%0b", nb, fd_b);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
